// File: rtl/ssd_scan_driver.sv
// ============================================================================
// ssd_scan_driver : multiplexed seven-segment scan driver, letter/hex decode
// rev 1.0
// ============================================================================
`default_nettype none

module ssd_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   codes_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_in,
  output logic [7:0]            segs,
  output logic [DIGITS-1:0]     ssd_ctl
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IDX_W-1:0]   C_IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [SCAN_W-1:0]  C_SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] C_BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;
  logic [3:0]         r_code [DIGITS];
  logic [DIGITS-1:0]  r_dp;
  logic [DIGITS-1:0]  r_blink;

  logic [3:0]         w_code;
  logic [7:0]         w_glyph;
  logic [7:0]         w_segs;
  logic [DIGITS-1:0]  w_ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_dp        <= '0;
      r_blink     <= '0;
      for (int i = 0; i < DIGITS; i++) r_code[i] <= 4'd0;
    end else begin
      if (r_scan_cnt == C_SCAN_LAST) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end

      if (r_blink_cnt == C_BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end

      if (load) begin
        r_dp    <= dp_in;
        r_blink <= blink_in;
        for (int i = 0; i < DIGITS; i++) r_code[i] <= codes_in[4*i +: 4];
      end
    end
  end

  // Glyphs are active-low {a,b,c,d,e,f,g,dp}; dp is left dark here.
  always_comb begin
    w_code  = r_code[r_idx];
    w_glyph = 8'hFF;
    if (mode) begin
      case (w_code)
        4'h0: w_glyph = 8'b0000_0011;
        4'h1: w_glyph = 8'b1001_1111;
        4'h2: w_glyph = 8'b0010_0101;
        4'h3: w_glyph = 8'b0000_1101;
        4'h4: w_glyph = 8'b1001_1001;
        4'h5: w_glyph = 8'b0100_1001;
        4'h6: w_glyph = 8'b0100_0001;
        4'h7: w_glyph = 8'b0001_1111;
        4'h8: w_glyph = 8'b0000_0001;
        4'h9: w_glyph = 8'b0000_1001;
        4'hA: w_glyph = 8'b0001_0001;
        4'hB: w_glyph = 8'b1100_0001;
        4'hC: w_glyph = 8'b0110_0011;
        4'hD: w_glyph = 8'b1000_0101;
        4'hE: w_glyph = 8'b0110_0001;
        default: w_glyph = 8'b0111_0001;
      endcase
    end else begin
      case (w_code)
        4'h0: w_glyph = 8'b1101_0101;
        4'h1: w_glyph = 8'b1110_0001;
        4'h2: w_glyph = 8'b1001_0001;
        4'h3: w_glyph = 8'b1000_0011;
        4'h4: w_glyph = 8'b0110_0001;
        4'h5: w_glyph = 8'b0111_0001;
        default: w_glyph = 8'hFF;
      endcase
    end

    w_segs = w_glyph;
    if (r_dp[r_idx]) w_segs[0] = 1'b0;
    // Blanking overrides the dp as well; the digit enable keeps scanning.
    if (r_phase && r_blink[r_idx]) w_segs = 8'hFF;

    w_ctl = ~(DIGITS'(1) << r_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segs    <= 8'hFF;
      ssd_ctl <= '1;
    end else begin
      segs    <= w_segs;
      ssd_ctl <= w_ctl;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
// ============================================================================
// tb_ssd_scan_driver : self-checking bench, arithmetic time-based display model
// rev 1.0
// ============================================================================
`default_nettype none

module tb_ssd_scan_driver;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                load;
  logic                mode;
  logic [4*DIGITS-1:0] codes_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blink_in;
  logic [7:0]          segs;
  logic [DIGITS-1:0]   ssd_ctl;

  int n_cmp = 0;
  int n_err = 0;

  // Model: non-reset edges since reset plus the shadow contents.
  int   m_k;
  int   m_code  [DIGITS];
  bit   m_dp    [DIGITS];
  bit   m_blink [DIGITS];
  logic [7:0]        exp_segs;
  logic [DIGITS-1:0] exp_ctl;

  always #5 clk = ~clk;

  ssd_scan_driver #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .mode    (mode),
    .codes_in(codes_in),
    .dp_in   (dp_in),
    .blink_in(blink_in),
    .segs    (segs),
    .ssd_ctl (ssd_ctl)
  );

  function automatic logic [7:0] letter_glyph(input int c);
    case (c)
      0: return 8'b1101_0101;
      1: return 8'b1110_0001;
      2: return 8'b1001_0001;
      3: return 8'b1000_0011;
      4: return 8'b0110_0001;
      5: return 8'b0111_0001;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] hex_glyph(input int c);
    logic [7:0] tbl [16];
    tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
            8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    return tbl[c];
  endfunction

  // Predict this edge's outputs from model state and present inputs, then advance.
  task automatic tick();
    int idx;
    int phase;
    if (rst) begin
      exp_segs = 8'hFF;
      exp_ctl  = '1;
    end else begin
      idx   = (m_k / SCAN_DIV) % DIGITS;
      phase = (m_k / BLINK_DIV) % 2;
      exp_segs = mode ? hex_glyph(m_code[idx]) : letter_glyph(m_code[idx]);
      if (m_dp[idx]) exp_segs[0] = 1'b0;
      if (phase == 1 && m_blink[idx]) exp_segs = 8'hFF;
      exp_ctl = '1;
      exp_ctl[idx] = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_k = 0;
      for (int i = 0; i < DIGITS; i++) begin
        m_code[i] = 0; m_dp[i] = 1'b0; m_blink[i] = 1'b0;
      end
    end else begin
      if (load) begin
        for (int i = 0; i < DIGITS; i++) begin
          m_code[i]  = int'(codes_in[4*i +: 4]);
          m_dp[i]    = dp_in[i];
          m_blink[i] = blink_in[i];
        end
      end
      m_k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; mode = 1'b0;
    codes_in = 16'($urandom); dp_in = 4'($urandom); blink_in = 4'($urandom);
    repeat (3) begin
      tick();
      n_cmp++;
      if (segs !== 8'hFF || ssd_ctl !== 4'b1111) begin
        n_err++;
        $display("FAIL reset_hold: segs=%b ctl=%b expected segs=11111111 ctl=1111", segs, ssd_ctl);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (segs !== 8'b1101_0101 || ssd_ctl !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_first_frame: segs=%b ctl=%b expected segs=11010101 ctl=1110", segs, ssd_ctl);
    end
  endtask

  task automatic test_letters();
    mode = 1'b0; dp_in = '0; blink_in = '0;
    codes_in = {4'd3, 4'd2, 4'd1, 4'd0};
    load = 1'b1;
    tick();
    load = 1'b0;
    codes_in = 16'($urandom);
    for (int t = 0; t < 20; t++) begin
      tick();
      n_cmp++;
      if (segs !== exp_segs || ssd_ctl !== exp_ctl) begin
        n_err++;
        $display("FAIL letters t=%0d: segs=%b ctl=%b expected segs=%b ctl=%b", t, segs, ssd_ctl, exp_segs, exp_ctl);
      end
    end
    codes_in = {4'd3, 4'd9, 4'd1, 4'd0};
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick();
      n_cmp++;
      if (segs !== exp_segs || ssd_ctl !== exp_ctl) begin
        n_err++;
        $display("FAIL letters_blank t=%0d: segs=%b ctl=%b expected segs=%b ctl=%b", t, segs, ssd_ctl, exp_segs, exp_ctl);
      end
    end
  endtask

  task automatic test_hex_dp();
    mode = 1'b1; blink_in = '0; dp_in = 4'b0010;
    codes_in = {4'hF, 4'hA, 4'h8, 4'h0};
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick();
      n_cmp++;
      if (segs !== exp_segs || ssd_ctl !== exp_ctl) begin
        n_err++;
        $display("FAIL hex_dp t=%0d: segs=%b ctl=%b expected segs=%b ctl=%b", t, segs, ssd_ctl, exp_segs, exp_ctl);
      end
      if (ssd_ctl === 4'b1101) begin
        n_cmp++;
        if (segs !== 8'b0000_0000) begin
          n_err++;
          $display("FAIL hex_dp_digit1: segs=%b expected 00000000", segs);
        end
      end
    end
  endtask

  task automatic test_blink();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 1'b1; dp_in = '0; blink_in = 4'b0001;
    codes_in = {4'hF, 4'hA, 4'h8, 4'h0};
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int t = 0; t < 48; t++) begin
      tick();
      n_cmp++;
      if (segs !== exp_segs || ssd_ctl !== exp_ctl) begin
        n_err++;
        $display("FAIL blink t=%0d: segs=%b ctl=%b expected segs=%b ctl=%b", t, segs, ssd_ctl, exp_segs, exp_ctl);
      end
    end
  endtask

  task automatic test_load_timing();
    blink_in = '0; dp_in = '0; mode = 1'b0; load = 1'b0;
    for (int t = 0; t < 8; t++) begin
      codes_in = 16'($urandom);
      tick();
      n_cmp++;
      if (segs !== exp_segs || ssd_ctl !== exp_ctl) begin
        n_err++;
        $display("FAIL load_ignored t=%0d: segs=%b ctl=%b expected segs=%b ctl=%b", t, segs, ssd_ctl, exp_segs, exp_ctl);
      end
    end
    for (int t = 0; t < SCAN_DIV && (m_k % SCAN_DIV) != SCAN_DIV - 1; t++) tick();
    codes_in = {4'd4, 4'd5, 4'd4, 4'd5};
    load = 1'b1;
    tick();
    load = 1'b0;
    codes_in = '0;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_cmp++;
      if (segs !== exp_segs || ssd_ctl !== exp_ctl) begin
        n_err++;
        $display("FAIL load_on_tick t=%0d: segs=%b ctl=%b expected segs=%b ctl=%b", t, segs, ssd_ctl, exp_segs, exp_ctl);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    found = 1'b0;
    for (int t = 0; t < 64 && !found; t++) begin
      if ((m_k % SCAN_DIV) == SCAN_DIV - 1 && ((m_k / SCAN_DIV) % DIGITS) == 2) found = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_reset_reach: idx=2 scan_cnt=3 not reached, actual k=%0d required a match", m_k);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (segs !== 8'hFF || ssd_ctl !== 4'b1111) begin
      n_err++;
      $display("FAIL mid_reset: segs=%b ctl=%b expected segs=11111111 ctl=1111", segs, ssd_ctl);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (segs !== exp_segs || ssd_ctl !== 4'b1110) begin
      n_err++;
      $display("FAIL mid_reset_resume: segs=%b ctl=%b expected segs=%b ctl=1110", segs, ssd_ctl, exp_segs);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      rst      = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 7) == 0);
      mode     = 1'($urandom);
      codes_in = 16'($urandom);
      dp_in    = 4'($urandom);
      blink_in = 4'($urandom);
      tick();
      n_cmp++;
      if (segs !== exp_segs || ssd_ctl !== exp_ctl) begin
        n_err++;
        $display("FAIL random t=%0d: segs=%b ctl=%b expected segs=%b ctl=%b", t, segs, ssd_ctl, exp_segs, exp_ctl);
      end
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; mode = 1'b0;
    codes_in = '0; dp_in = '0; blink_in = '0;
    m_k = 0;
    for (int i = 0; i < DIGITS; i++) begin
      m_code[i] = 0; m_dp[i] = 1'b0; m_blink[i] = 1'b0;
    end
    test_reset();
    test_letters();
    test_hex_dp();
    test_blink();
    test_load_timing();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
